// File: rtl/pipe_halt_ctrl.sv
// Pipeline stall/flush/halt controller: merges core hazards with debugger halt/resume/step.
// Latency: control outputs are combinational from state and hazards; halted is registered.
// Backpressure: DRAIN waits for PIPE_DEPTH non-stalled cycles before reporting halted.
module pipe_halt_ctrl #(
  parameter int PIPE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use_hazard,
  input  logic        branch_flush,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        step_req,
  output logic        Stall,
  output logic        reset_stages,
  output logic        fetch_kill,
  output logic        pc_hold,
  output logic        halted,
  output logic [31:0] stall_count
);

  localparam int CW = $clog2(PIPE_DEPTH + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(PIPE_DEPTH);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_drain_cnt;
  logic [CW-1:0]   w_next_drain_cnt;
  logic            r_halted;
  logic [31:0]     r_stall_count;
  logic            w_hazard_stall;
  logic            w_count_en;

  // A taken branch squashes the dependent instruction, so it overrides a load-use stall.
  assign w_hazard_stall = load_use_hazard & ~branch_flush;

  // Next-state, drain counter and control outputs.
  always_comb begin
    w_next_state     = r_state;
    w_next_drain_cnt = r_drain_cnt;
    Stall            = 1'b0;
    reset_stages     = 1'b0;
    fetch_kill       = 1'b0;
    pc_hold          = 1'b0;
    case (r_state)
      S_RUN: begin
        Stall        = w_hazard_stall;
        reset_stages = branch_flush;
        pc_hold      = w_hazard_stall;
        if (halt_req) begin
          w_next_state     = S_DRAIN;
          w_next_drain_cnt = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        // Fetch is frozen; instructions already in flight keep flowing out.
        Stall        = w_hazard_stall;
        reset_stages = branch_flush;
        fetch_kill   = 1'b1;
        pc_hold      = 1'b1;
        // Only cycles where the pipe actually advances retire a slot.
        if (!w_hazard_stall) begin
          w_next_drain_cnt = r_drain_cnt - DRAIN_LAST;
          if (r_drain_cnt <= DRAIN_LAST) begin
            w_next_state     = S_HALTED;
            w_next_drain_cnt = '0;
          end
        end
      end
      S_HALTED: begin
        Stall      = 1'b1;
        fetch_kill = 1'b1;
        pc_hold    = 1'b1;
        if (resume_req) begin
          w_next_state = S_RUN;
        end else if (step_req) begin
          w_next_state = S_STEP;
        end
      end
      S_STEP: begin
        // One free cycle lets exactly one instruction enter, then drain it out.
        w_next_state     = S_DRAIN;
        w_next_drain_cnt = DRAIN_LOAD;
      end
      default: begin
        w_next_state     = S_RUN;
        w_next_drain_cnt = '0;
      end
    endcase
  end

  // Hazard stalls are counted only while the core is executing or draining.
  assign w_count_en = Stall & ((r_state == S_RUN) | (r_state == S_DRAIN));

  // State and drain counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain_cnt;
    end
  end

  // Registered halted flag, tracking entry into HALTED on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= (w_next_state == S_HALTED);
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_count_en && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign halted      = r_halted;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_halt_ctrl.sv
// Directed bench for pipe_halt_ctrl: stimulus pushes expected outputs, monitor compares.
// Each cycle: inputs driven at negedge, expectations checked 2 time units later.
// Registered outputs reflect the preceding posedge; control outputs reflect current inputs.
`timescale 1ns/1ps
module tb_pipe_halt_ctrl;

  logic        clk;
  logic        reset;
  logic        load_use_hazard;
  logic        branch_flush;
  logic        halt_req;
  logic        resume_req;
  logic        step_req;
  logic        Stall;
  logic        reset_stages;
  logic        fetch_kill;
  logic        pc_hold;
  logic        halted;
  logic [31:0] stall_count;

  typedef struct {
    string       nm;
    logic        st;
    logic        rs;
    logic        fk;
    logic        ph;
    logic        hl;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_halt_ctrl #(.PIPE_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_use_hazard(load_use_hazard),
    .branch_flush   (branch_flush),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .step_req       (step_req),
    .Stall          (Stall),
    .reset_stages   (reset_stages),
    .fetch_kill     (fetch_kill),
    .pc_hold        (pc_hold),
    .halted         (halted),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s actual=%h expected=%h @%0t", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the stimulus has queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "Stall",        {31'd0, Stall},        {31'd0, e.st});
        chk(e.nm, "reset_stages", {31'd0, reset_stages}, {31'd0, e.rs});
        chk(e.nm, "fetch_kill",   {31'd0, fetch_kill},   {31'd0, e.fk});
        chk(e.nm, "pc_hold",      {31'd0, pc_hold},      {31'd0, e.ph});
        chk(e.nm, "halted",       {31'd0, halted},       {31'd0, e.hl});
        chk(e.nm, "stall_count",  stall_count,           e.cnt);
      end
    end
  end

  // One cycle: drive inputs at negedge, queue the expected response.
  task automatic cyc(input string nm,
                     input logic lu, input logic bf, input logic hr, input logic rr, input logic sr,
                     input logic st, input logic rs, input logic fk, input logic ph, input logic hl,
                     input logic [31:0] cnt);
    exp_t e;
    @(negedge clk);
    load_use_hazard = lu;
    branch_flush    = bf;
    halt_req        = hr;
    resume_req      = rr;
    step_req        = sr;
    #1;
    e.nm = nm; e.st = st; e.rs = rs; e.fk = fk; e.ph = ph; e.hl = hl; e.cnt = cnt;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    load_use_hazard = 1'b0; branch_flush = 1'b0; halt_req = 1'b0;
    resume_req = 1'b0; step_req = 1'b0;

    //            name        lu bf hr rr sr   St rs fk ph hl  count
    cyc("reset",              0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'd0);
    @(negedge clk); reset = 1'b0;
    cyc("idle0",              0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'd0);
    // Load-use stall for three cycles
    cyc("lu1",                1, 0, 0, 0, 0,   1, 0, 0, 1, 0,  32'd0);
    cyc("lu2",                1, 0, 0, 0, 0,   1, 0, 0, 1, 0,  32'd1);
    cyc("lu3",                1, 0, 0, 0, 0,   1, 0, 0, 1, 0,  32'd2);
    cyc("lu_done",            0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'd3);
    // Branch flush beats load-use
    cyc("lu_bf",              1, 1, 0, 0, 0,   0, 1, 0, 0, 0,  32'd3);
    cyc("after_bf",           0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'd3);
    // Clean halt: 4 drain cycles, then halted
    cyc("halt_req",           0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  32'd3);
    cyc("drain1",             0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd3);
    cyc("drain2",             0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd3);
    cyc("drain3",             0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd3);
    cyc("drain4",             0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd3);
    cyc("halted_a",           1, 0, 1, 0, 0,   1, 0, 1, 1, 1,  32'd3);
    cyc("halted_bf",          0, 1, 0, 0, 0,   1, 0, 1, 1, 1,  32'd3);
    cyc("halted_c",           0, 0, 0, 0, 0,   1, 0, 1, 1, 1,  32'd3);
    cyc("resume",             0, 0, 0, 1, 0,   1, 0, 1, 1, 1,  32'd3);
    cyc("run_ignore_rs",      0, 0, 0, 1, 1,   0, 0, 0, 0, 0,  32'd3);
    cyc("run_still",          0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'd3);
    // Halt with two stalled drain cycles
    cyc("halt2_req",          0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  32'd3);
    cyc("d_stall1",           1, 0, 0, 0, 0,   1, 0, 1, 1, 0,  32'd3);
    cyc("d_stall2",           1, 0, 0, 0, 0,   1, 0, 1, 1, 0,  32'd4);
    cyc("d2_1",               0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("d2_2",               0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("d2_3",               0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("d2_4",               0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("halted2",            0, 0, 0, 0, 0,   1, 0, 1, 1, 1,  32'd5);
    // Single step; a flush mid-drain does not stretch it
    cyc("step_req",           0, 0, 0, 0, 1,   1, 0, 1, 1, 1,  32'd5);
    cyc("step",               1, 0, 1, 0, 0,   0, 0, 0, 0, 0,  32'd5);
    cyc("sd1",                0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("sd2_bf",             1, 1, 0, 0, 0,   0, 1, 1, 1, 0,  32'd5);
    cyc("sd3",                0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("sd4",                0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("halted3",            0, 0, 0, 0, 0,   1, 0, 1, 1, 1,  32'd5);
    // Resume and step together: resume wins
    cyc("resume_step",        0, 0, 0, 1, 1,   1, 0, 1, 1, 1,  32'd5);
    cyc("run_again",          0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'd5);
    // Halt together with a flush, then reset mid-drain at drain_cnt=2
    cyc("halt_bf",            1, 1, 1, 0, 0,   0, 1, 0, 0, 0,  32'd5);
    cyc("rd1",                0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    cyc("rd2",                0, 0, 0, 0, 0,   0, 0, 1, 1, 0,  32'd5);
    @(negedge clk); reset = 1'b1;
    #1;
    q.push_back('{nm: "mid_reset", st: 1'b0, rs: 1'b0, fk: 1'b0, ph: 1'b0, hl: 1'b0, cnt: 32'd0});
    @(negedge clk); reset = 1'b0;
    cyc("post_rst_lu",        1, 0, 0, 0, 0,   1, 0, 0, 1, 0,  32'd0);
    cyc("post_rst_idle",      0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'd1);
    // Saturation: preload the counter just below the limit
    #2;
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_count;
    cyc("sat1",               1, 0, 0, 0, 0,   1, 0, 0, 1, 0,  32'hFFFF_FFFE);
    cyc("sat2",               1, 0, 0, 0, 0,   1, 0, 0, 1, 0,  32'hFFFF_FFFF);
    cyc("sat3",               1, 0, 0, 0, 0,   1, 0, 0, 1, 0,  32'hFFFF_FFFF);
    cyc("sat_hold",           0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  32'hFFFF_FFFF);

    @(negedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending entries", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_halt_ctrl.md
# pipe_halt_ctrl

Pipeline control stage that generates the `Stall` and `reset_stages` controls consumed by every inter-stage pipeline register, plus fetch-side hold/kill controls. It merges core hazards (load-use stall, taken-branch flush) with external-debugger halt, resume and single-step requests. It drains in-flight instructions before reporting halted. It sits between the hazard/debug sources and the pipeline register chain.

## Interface
- `PIPE_DEPTH`, default 4: number of pipeline registers after fetch that must empty before halt completes (IF/ID, ID/EX, EX/MEM, MEM/WB).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `load_use_hazard` in 1: decode detected load-use dependency this cycle.
- `branch_flush` in 1: execute resolved a taken branch/jump this cycle.
- `halt_req` in 1: debugger halt request, level, sampled each edge.
- `resume_req` in 1: debugger resume request, sampled each edge.
- `step_req` in 1: debugger single-step request, sampled each edge.
- `Stall` out 1: hold all pipeline registers.
- `reset_stages` out 1: flush front pipeline registers (IF/ID, ID/EX).
- `fetch_kill` out 1: force bubble into IF/ID input.
- `pc_hold` out 1: PC does not advance sequentially; a branch redirect still takes effect.
- `halted` out 1: core halted, pipeline empty.
- `stall_count` out 32: saturating count of hazard stall cycles.

## Operation
- States: RUN, DRAIN, HALTED, STEP. Reset state is RUN.
- Reset values: state=RUN, drain_cnt=0, halted=0, stall_count=0.
- Outputs are combinational from state and hazard inputs:
  - RUN: `Stall`=load_use_hazard & ~branch_flush; `reset_stages`=branch_flush; `fetch_kill`=0; `pc_hold`=`Stall`.
  - DRAIN: `fetch_kill`=1, `pc_hold`=1; `Stall` and `reset_stages` as in RUN.
  - HALTED: `Stall`=1, `fetch_kill`=1, `pc_hold`=1, `reset_stages`=0.
  - STEP: all four = 0.
- `branch_flush` has priority over `load_use_hazard` in every state.
- Transitions:
  - RUN --halt_req--> DRAIN. On entry, load drain_cnt=PIPE_DEPTH.
  - DRAIN: decrement drain_cnt on each cycle with `Stall`=0. If drain_cnt==1 and `Stall`=0, go to HALTED.
  - HALTED --resume_req--> RUN.
  - HALTED --step_req & ~resume_req--> STEP. resume_req has priority.
  - STEP --> DRAIN unconditionally after 1 cycle, reloading drain_cnt=PIPE_DEPTH.
- Ignored requests:
  - halt_req in DRAIN, HALTED or STEP.
  - resume_req and step_req in RUN, DRAIN or STEP.
- `halted` is registered and equals 1 exactly when state==HALTED.
- `stall_count`:
  - +1 on every edge where `Stall`=1 in RUN or DRAIN.
  - Never counts in HALTED.
  - Saturates at 0xFFFF_FFFF.
- drain_cnt width is $clog2(PIPE_DEPTH+1).
- A branch_flush during DRAIN flushes wrong-path instructions. The PC redirect still applies. drain_cnt keeps counting.

## Timing
- halt_req high at edge N in RUN: state=DRAIN from N. With no stalls, `halted`=1 after edge N+PIPE_DEPTH.
- Each DRAIN cycle with `Stall`=1 extends the halt latency by one cycle.
- resume_req at edge M in HALTED: `halted`=0 and RUN outputs take effect after M.
- Single step: STEP lasts exactly 1 cycle, fetching exactly one instruction. `halted` returns PIPE_DEPTH+1 cycles after the step_req edge, with no stalls.
- Asynchronous reset at any time, including mid-DRAIN or STEP: all state and outputs go immediately to reset values. Outputs then follow RUN equations.
- halt_req and branch_flush in the same cycle in RUN: the flush applies that cycle, and DRAIN starts at the next edge.

## Test plan
- Reset release, no requests, load_use_hazard pulsed 3 cycles:
  - `Stall`=1 for exactly those 3 cycles.
  - `stall_count`=3.
  - `halted`=0.
- load_use_hazard and branch_flush both high one cycle: `Stall`=0 and `reset_stages`=1 that cycle; `stall_count` unchanged.
- halt_req at edge 10, no hazards, PIPE_DEPTH=4:
  - `fetch_kill`=`pc_hold`=1 from cycle 10.
  - `halted`=1 after edge 14.
  - `Stall`=1 while halted.
- halt_req at edge 10 with load_use_hazard during 2 DRAIN cycles: `halted` after edge 16; `stall_count`=2.
- In HALTED:
  - step_req: one cycle with all controls 0, then `halted`=1 again 5 cycles after the request edge.
  - resume_req and step_req together: RUN.
- Assert reset mid-DRAIN (drain_cnt=2): `halted`=0, `fetch_kill`=0, `stall_count`=0 immediately. The FSM resumes in RUN.
- Force `stall_count`=0xFFFF_FFFE, then 3 stall cycles: the count holds at 0xFFFF_FFFF.
